// File: rtl/radix_2_pipe.sv
// radix_2_pipe: pipelined modular radix-2 butterfly for an NTT/INTT datapath.
//
// Per accepted sample (a = input_1, b = input_2, w = input_twiddle):
//   select = 0 (NTT, Cooley-Tukey):    output_1 = a + b*w,  output_2 = a - b*w      (mod Q)
//   select = 1 (INTT, Gentleman-Sande): output_1 = a + b,    output_2 = (a - b)*w    (mod Q)
//   select = 1 and half = 1: both INTT results are additionally multiplied by 2^-1 mod Q.
//
// Ports:
//   clk, rst                  rising-edge clock, synchronous active-high reset
//   in_valid / in_ready       upstream handshake; in_ready = ~(out_valid & ~out_ready)
//   input_1, input_2          coefficients a, b (< Q)
//   input_twiddle             twiddle w (< Q)
//   select, half, in_last     per-sample mode bits and sideband, travel with the sample
//   out_valid / out_ready     downstream handshake
//   output_1, output_2        butterfly results (< Q)
//   out_last                  in_last of the sample being presented
//
// Pipeline: input stage (INTT add/sub) -> MULT_STAGES multiplier stages -> output stage
// (reduction, NTT add/sub, optional halving). Latency MULT_STAGES + 2, all stages share a
// single advance enable so a stalled output freezes the whole pipe.
module radix_2_pipe #(
  parameter int unsigned width       = 16,
  parameter int unsigned Q           = 12289,
  parameter int unsigned MULT_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [width-1:0] input_1,
  input  logic [width-1:0] input_2,
  input  logic [width-1:0] input_twiddle,
  input  logic             select,
  input  logic             half,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [width-1:0] output_1,
  output logic [width-1:0] output_2,
  output logic             out_last
);

  localparam int unsigned PW   = 2 * width;
  localparam int unsigned LAST = MULT_STAGES - 1;
  localparam logic [width:0]  QE = (width + 1)'(Q);
  localparam logic [PW-1:0]   QP = PW'(Q);

  function automatic logic [width-1:0] mod_add(input logic [width-1:0] x,
                                               input logic [width-1:0] y);
    logic [width:0] s;
    s = {1'b0, x} + {1'b0, y};
    if (s >= QE) s = s - QE;
    return s[width-1:0];
  endfunction

  function automatic logic [width-1:0] mod_sub(input logic [width-1:0] x,
                                               input logic [width-1:0] y);
    logic [width:0] d;
    d = {1'b0, x} - {1'b0, y};
    // A borrow wraps the width+1 intermediate; adding Q restores the low bits exactly.
    if (x < y) d = d + QE;
    return d[width-1:0];
  endfunction

  // r * 2^-1 mod Q: odd r becomes even after adding the odd modulus.
  function automatic logic [width-1:0] mod_half(input logic [width-1:0] r);
    logic [width:0] t;
    t = r[0] ? ({1'b0, r} + QE) : {1'b0, r};
    t = t >> 1;
    return t[width-1:0];
  endfunction

  logic stall, adv;
  assign stall    = out_valid & ~out_ready;
  assign adv      = ~stall;
  assign in_ready = ~stall;

  // Input stage: for INTT the add/sub happens before the multiplier so that the
  // multiplier operand is b (NTT) or a-b (INTT), and the bypass term is a or a+b.
  logic             s0_valid_q;
  logic [width-1:0] s0_x_q, s0_w_q, s0_p_q;
  logic             s0_sel_q, s0_half_q, s0_last_q;
  logic [width-1:0] s0_x_d, s0_p_d;

  always_comb begin
    s0_x_d = input_2;
    s0_p_d = input_1;
    if (select) begin
      s0_x_d = mod_sub(input_1, input_2);
      s0_p_d = mod_add(input_1, input_2);
    end
  end

  // Multiplier stages: product registered on entry, then delayed; the bypass term and
  // mode bits ride alongside to keep the pipe balanced.
  logic             m_valid_q [MULT_STAGES];
  logic [PW-1:0]    m_prod_q  [MULT_STAGES];
  logic [width-1:0] m_p_q     [MULT_STAGES];
  logic             m_sel_q   [MULT_STAGES];
  logic             m_half_q  [MULT_STAGES];
  logic             m_last_q  [MULT_STAGES];
  logic [PW-1:0]    prod;

  assign prod = {{width{1'b0}}, s0_x_q} * {{width{1'b0}}, s0_w_q};

  // Output stage next-state.
  logic [width-1:0] m_red, p_last, r1_d, r2_d;

  always_comb begin
    m_red  = width'(m_prod_q[LAST] % QP);
    p_last = m_p_q[LAST];
    r1_d   = mod_add(p_last, m_red);
    r2_d   = mod_sub(p_last, m_red);
    if (m_sel_q[LAST]) begin
      r1_d = p_last;
      r2_d = m_red;
      if (m_half_q[LAST]) begin
        r1_d = mod_half(p_last);
        r2_d = mod_half(m_red);
      end
    end
  end

  logic             out_valid_q, out_last_q;
  logic [width-1:0] out1_q, out2_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      s0_valid_q  <= 1'b0;
      s0_x_q      <= '0;
      s0_w_q      <= '0;
      s0_p_q      <= '0;
      s0_sel_q    <= 1'b0;
      s0_half_q   <= 1'b0;
      s0_last_q   <= 1'b0;
      for (int i = 0; i < MULT_STAGES; i++) begin
        m_valid_q[i] <= 1'b0;
        m_prod_q[i]  <= '0;
        m_p_q[i]     <= '0;
        m_sel_q[i]   <= 1'b0;
        m_half_q[i]  <= 1'b0;
        m_last_q[i]  <= 1'b0;
      end
      out_valid_q <= 1'b0;
      out1_q      <= '0;
      out2_q      <= '0;
      out_last_q  <= 1'b0;
    end else if (adv) begin
      // in_ready equals adv, so loading in_valid here is exactly the input transfer.
      s0_valid_q  <= in_valid;
      s0_x_q      <= s0_x_d;
      s0_w_q      <= input_twiddle;
      s0_p_q      <= s0_p_d;
      s0_sel_q    <= select;
      s0_half_q   <= half;
      s0_last_q   <= in_last;
      m_valid_q[0] <= s0_valid_q;
      m_prod_q[0]  <= prod;
      m_p_q[0]     <= s0_p_q;
      m_sel_q[0]   <= s0_sel_q;
      m_half_q[0]  <= s0_half_q;
      m_last_q[0]  <= s0_last_q;
      for (int i = 1; i < MULT_STAGES; i++) begin
        m_valid_q[i] <= m_valid_q[i-1];
        m_prod_q[i]  <= m_prod_q[i-1];
        m_p_q[i]     <= m_p_q[i-1];
        m_sel_q[i]   <= m_sel_q[i-1];
        m_half_q[i]  <= m_half_q[i-1];
        m_last_q[i]  <= m_last_q[i-1];
      end
      out_valid_q <= m_valid_q[LAST];
      out1_q      <= r1_d;
      out2_q      <= r2_d;
      out_last_q  <= m_last_q[LAST];
    end
  end

  assign out_valid = out_valid_q;
  assign output_1  = out1_q;
  assign output_2  = out2_q;
  assign out_last  = out_last_q;

endmodule

// File: tb/tb_radix_2_pipe.sv
// Testbench for radix_2_pipe: directed butterfly cases, boundary values, reset flush and a
// randomized backpressured stream, all checked against an arithmetic reference model.
module tb_radix_2_pipe;

  localparam int unsigned W  = 16;
  localparam int unsigned Q  = 12289;
  localparam int unsigned MS = 2;
  localparam int unsigned L  = MS + 2;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] input_1;
  logic [W-1:0] input_2;
  logic [W-1:0] input_twiddle;
  logic         select;
  logic         half;
  logic         in_last;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] output_1;
  logic [W-1:0] output_2;
  logic         out_last;

  radix_2_pipe #(
    .width      (W),
    .Q          (Q),
    .MULT_STAGES(MS)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .input_1      (input_1),
    .input_2      (input_2),
    .input_twiddle(input_twiddle),
    .select       (select),
    .half         (half),
    .in_last      (in_last),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .output_1     (output_1),
    .output_2     (output_2),
    .out_last     (out_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    longint unsigned o1;
    longint unsigned o2;
    bit              last;
  } exp_t;

  exp_t         exp_q[$];
  int           checks;
  int           errors;
  bit           stalled_prev;
  logic [W-1:0] h1, h2;
  logic         hl;
  bit           in_fire, out_fire;
  bit           chk_reset, chk_idle;
  logic [W-1:0] got1, got2;
  int           n_out;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference butterfly straight from the modular definitions.
  function automatic exp_t model(input longint unsigned a, input longint unsigned b,
                                 input longint unsigned w, input bit sel, input bit hf,
                                 input bit lst);
    exp_t e;
    longint unsigned t, r1, r2, inv2;
    inv2 = (Q + 1) / 2;
    if (!sel) begin
      t  = (b * w) % Q;
      r1 = (a + t) % Q;
      r2 = (a + Q - t) % Q;
    end else begin
      r1 = (a + b) % Q;
      r2 = (((a + Q - b) % Q) * w) % Q;
      if (hf) begin
        r1 = (r1 * inv2) % Q;
        r2 = (r2 * inv2) % Q;
      end
    end
    e.o1   = r1;
    e.o2   = r2;
    e.last = lst;
    return e;
  endfunction

  // Runs just before the active edge: scoreboards both handshakes for this cycle.
  task automatic observe();
    exp_t e;
    in_fire  = in_valid && in_ready && !rst;
    out_fire = out_valid && out_ready && !rst;
    check("in_ready_vs_stall", in_ready, !(out_valid && !out_ready));
    if (stalled_prev) begin
      check("stall_hold_valid", out_valid, 1);
      check("stall_hold_o1", output_1, h1);
      check("stall_hold_o2", output_2, h2);
      check("stall_hold_last", out_last, hl);
    end
    if (chk_reset) begin
      check("rst_out_valid", out_valid, 0);
      check("rst_output_1", output_1, 0);
      check("rst_output_2", output_2, 0);
      check("rst_out_last", out_last, 0);
      check("rst_in_ready", in_ready, 1);
      chk_reset = 0;
    end
    if (chk_idle) check("flushed_out_valid", out_valid, 0);
    if (out_fire) begin
      if (exp_q.size() == 0) begin
        check("spurious_output", out_valid, 0);
      end else begin
        e = exp_q.pop_front();
        check("output_1", output_1, e.o1);
        check("output_2", output_2, e.o2);
        check("out_last", out_last, e.last);
        check("output_range", (output_1 < Q) && (output_2 < Q), 1);
        got1 = output_1;
        got2 = output_2;
        n_out++;
      end
    end
    stalled_prev = out_valid && !out_ready && !rst;
    h1 = output_1;
    h2 = output_2;
    hl = out_last;
    if (in_fire) exp_q.push_back(model(input_1, input_2, input_twiddle, select, half, in_last));
  endtask

  task automatic cycle_io(input bit r, input bit v, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [W-1:0] w, input bit s,
                          input bit h, input bit l, input bit ordy);
    @(negedge clk);
    rst           = r;
    in_valid      = v;
    input_1       = a;
    input_2       = b;
    input_twiddle = w;
    select        = s;
    half          = h;
    in_last       = l;
    out_ready     = ordy;
    #1;
    observe();
    @(posedge clk);
  endtask

  task automatic idle(input bit ordy);
    cycle_io(1'b0, 1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b0, ordy);
  endtask

  // One reset cycle; a sample is offered meanwhile and must not be accepted.
  task automatic do_reset();
    cycle_io(1'b1, 1'b1, W'(7), W'(9), W'(11), 1'b0, 1'b0, 1'b1, 1'b0);
    exp_q.delete();
    stalled_prev = 0;
    chk_reset    = 1;
  endtask

  // Single sample on an empty pipe with out_ready held high; checks the latency.
  task automatic run_sample(input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic [W-1:0] w, input bit s, input bit h);
    int lat;
    cycle_io(1'b0, 1'b1, a, b, w, s, h, 1'b1, 1'b1);
    lat = -1;
    for (int c = 1; c <= 20; c++) begin
      idle(1'b1);
      if (out_fire) begin
        lat = c;
        break;
      end
    end
    check("latency", lat, L);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [W-1:0] bv [3][3];
    logic [W-1:0] sa, sb, sw;
    bit           ss, sh, sl, ordy;
    int           sent;

    checks = 0;
    errors = 0;
    stalled_prev = 0;
    chk_reset = 0;
    chk_idle = 0;
    n_out = 0;
    rst = 1'b1;
    in_valid = 1'b0;
    input_1 = '0;
    input_2 = '0;
    input_twiddle = '0;
    select = 1'b0;
    half = 1'b0;
    in_last = 1'b0;
    out_ready = 1'b0;

    do_reset();
    do_reset();
    idle(1'b1);

    // Directed butterflies with hand-computed results.
    run_sample(W'(5), W'(3), W'(2), 1'b0, 1'b0);
    check("ntt_5_3_2_o1", got1, 11);
    check("ntt_5_3_2_o2", got2, 12288);
    run_sample(W'(5), W'(3), W'(4), 1'b1, 1'b0);
    check("intt_5_3_4_o1", got1, 8);
    check("intt_5_3_4_o2", got2, 8);
    run_sample(W'(5), W'(3), W'(4), 1'b1, 1'b1);
    check("intt_half_5_3_4_o1", got1, 4);
    check("intt_half_5_3_4_o2", got2, 4);
    run_sample(W'(3), W'(5), W'(1), 1'b1, 1'b1);
    check("intt_half_3_5_1_o1", got1, 4);
    check("intt_half_3_5_1_o2", got2, 12288);

    // Boundary operands in NTT, INTT and INTT-with-halving.
    bv[0][0] = W'(Q - 1); bv[0][1] = W'(Q - 1); bv[0][2] = W'(Q - 1);
    bv[1][0] = W'(0);     bv[1][1] = W'(Q - 1); bv[1][2] = W'(1);
    bv[2][0] = W'(0);     bv[2][1] = W'(0);     bv[2][2] = W'(0);
    for (int i = 0; i < 3; i++) begin
      run_sample(bv[i][0], bv[i][1], bv[i][2], 1'b0, 1'b0);
      run_sample(bv[i][0], bv[i][1], bv[i][2], 1'b1, 1'b0);
      run_sample(bv[i][0], bv[i][1], bv[i][2], 1'b1, 1'b1);
    end

    // Randomized stream with backpressure, including a 10-cycle stall window.
    n_out = 0;
    sent  = 0;
    sa = W'($urandom_range(0, Q - 1));
    sb = W'($urandom_range(0, Q - 1));
    sw = W'($urandom_range(0, Q - 1));
    ss = 1'($urandom_range(0, 1));
    sh = 1'($urandom_range(0, 1));
    sl = 1'($urandom_range(0, 1));
    for (int cyc = 0; cyc < 3000 && (sent < 64 || exp_q.size() > 0); cyc++) begin
      ordy = (cyc >= 20 && cyc < 30) ? 1'b0 : ($urandom_range(0, 3) != 0);
      cycle_io(1'b0, sent < 64, sa, sb, sw, ss, sh, sl, ordy);
      if (in_fire) begin
        sent++;
        sa = W'($urandom_range(0, Q - 1));
        sb = W'($urandom_range(0, Q - 1));
        sw = W'($urandom_range(0, Q - 1));
        ss = 1'($urandom_range(0, 1));
        sh = 1'($urandom_range(0, 1));
        sl = 1'($urandom_range(0, 1));
      end
    end
    check("stream_outputs", n_out, 64);
    check("stream_drained", exp_q.size(), 0);

    // Reset with L-1 samples in flight and the output blocked.
    for (int i = 0; i < int'(L) - 1; i++)
      cycle_io(1'b0, 1'b1, W'(100 + i), W'(200 + i), W'(3), 1'b0, 1'b0, 1'b0, 1'b0);
    do_reset();
    chk_idle = 1;
    for (int i = 0; i < int'(L) + 2; i++) idle(1'b1);
    chk_idle = 0;
    run_sample(W'(5), W'(3), W'(2), 1'b0, 1'b0);
    check("post_reset_o1", got1, 11);
    check("post_reset_o2", got2, 12288);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/radix_2_pipe.md
# radix_2_pipe

Pipelined, parametrised modular radix-2 butterfly for the NTT/INTT datapath. Each cycle it accepts one coefficient pair plus twiddle and returns the butterfly pair after a fixed latency. NTT samples use the Cooley-Tukey form and INTT samples use the Gentleman-Sande form, with optional halving for the final INTT scaling. Valid/ready handshakes on both sides let it sit between the coefficient memory read port and the write-back path of a stage controller, with full backpressure.

## Interface

- `width`, 16: bit width of coefficients, twiddle and outputs.
- `Q`, 12289: prime modulus. Q < 2^width, Q odd.
- `MULT_STAGES`, 2: register stages inside the modular multiplier, ≥1.
- `clk` input, 1 bit: rising-edge clock; the only clock.
- `rst` input, 1 bit: synchronous, active-high reset.
- `in_valid` input, 1 bit: input sample present.
- `in_ready` output, 1 bit: block can accept a sample this cycle.
- `input_1` input, `width` bits: coefficient a, < Q.
- `input_2` input, `width` bits: coefficient b, < Q.
- `input_twiddle` input, `width` bits: twiddle w, < Q.
- `select` input, 1 bit: 0 selects NTT (CT), 1 selects INTT (GS); sampled per accepted sample.
- `half` input, 1 bit: INTT only, multiplies both outputs by 2^-1 mod Q; ignored when `select`=0.
- `in_last` input, 1 bit: sideband flag, delivered unchanged with the sample.
- `out_valid` output, 1 bit: output sample present.
- `out_ready` input, 1 bit: downstream accepts the sample.
- `output_1` output, `width` bits: first butterfly result, < Q.
- `output_2` output, `width` bits: second butterfly result, < Q.
- `out_last` output, 1 bit: `in_last` of this sample.

## Operation

- A transfer occurs on an edge where valid and ready are both 1, on either side.
- NTT: `output_1` = (a + b·w) mod Q, `output_2` = (a − b·w) mod Q.
- INTT: `output_1` = (a + b) mod Q, `output_2` = ((a − b)·w) mod Q.
- INTT with `half`=1: each result r is replaced by r/2 mod Q. The rule is: r even gives r>>1; r odd gives (r+Q)>>1. The intermediate needs width+1 bits.
- Mod add: if the sum ≥ Q, subtract Q. Mod sub: if the difference < 0, add Q. Intermediates are width+1 bits.
- Mod mult: the full 2·width product is reduced to [0,Q) by any method, provided the result is exact for all inputs < Q.
- `select`, `half` and `in_last` are registered with the sample. Mixed modes in flight are legal, and each sample uses its own mode.
- Inputs ≥ Q are out of contract and give undefined results. This is not checked.

## Timing

- Latency is L = MULT_STAGES + 2 cycles, from the accepting edge to `out_valid`=1, for both modes, with or without `half`. The pipeline is balanced so that output order equals input order.
- Throughput is one sample per cycle when `out_ready` is held at 1.
- Stall rule: `stall` = `out_valid` & ~`out_ready`.
  - `in_ready` = ~`stall`, combinational.
  - During a stall, every pipeline register holds its value.
  - During a stall, the output data and `out_last` stay stable while `out_valid`=1.
- Every stage carries a valid bit. Bubbles, meaning `in_valid`=0 cycles, propagate as valid=0. A bubble at the output never stalls the pipeline.
- Reset:
  - On a `rst` edge, all stage valid bits clear, which flushes in-flight samples.
  - `out_valid`=0, `output_1`=0, `output_2`=0 and `out_last`=0 from the cycle after the reset edge.
  - `in_ready`=1 one cycle after reset.
  - Reset mid-stall discards the held sample.
  - Inputs presented during `rst`=1 are not accepted.
- Simultaneous events: when the output is accepted on the same edge as a new input, both transfers complete and no bubble is inserted.

## Test plan

- NTT, Q=12289, a=5, b=3, w=2 → after L cycles `output_1`=11, `output_2`=12288.
- INTT, `half`=0, a=5, b=3, w=4 → `output_1`=8, `output_2`=8. With `half`=1, the same inputs give `output_1`=4, `output_2`=4.
- INTT with `half`=1, a=3, b=5, w=1 → `output_1`=4, `output_2`=12288, which exercises the odd halving path and the sub wrap.
- Streaming with backpressure:
  - Stimulus: 64 random samples back-to-back with mixed `select`/`half`/`in_last`. `out_ready` toggles pseudo-randomly, including low for 10 consecutive cycles.
  - Required: all 64 results match the golden model in order, with no drops or duplicates. Outputs are stable while stalled, and `in_ready` mirrors `stall`.
- Boundary values: a=b=w=Q−1 and a=0, b=Q−1, w=1 in both modes, plus all-zero inputs → exact golden match, with every output < Q.
- Reset mid-operation:
  - Stimulus: assert `rst` for 1 cycle while L−1 samples are in flight and `out_ready`=0.
  - Required: `out_valid`=0 next cycle, no flushed sample ever appears, and the first post-reset sample emerges after exactly L cycles.
